// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the async-read ROM address and
// buffers returned words, tagged with their PC, in a small FIFO towards decode.
// Optional bounds/alignment check enabled by defining IFETCH_BOUNDS_CHECK_EN.
module ifetch_ctrl #(
  parameter int unsigned          ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC   = '0,
  parameter int unsigned          FIFO_DEPTH = 2,
  parameter int unsigned          MEM_WORDS  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [ADDR_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready,
  output logic              busy,
  output logic [31:0]       fetch_cnt,
  output logic              fault
);

  localparam int unsigned     PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned     CntW     = PtrW + 1;
  localparam logic [CntW-1:0] Depth    = CntW'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] MemLimit = (ADDR_W + 1)'(MEM_WORDS) << 2;

`ifdef IFETCH_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  // Without the check, out-of-range addresses simply wrap inside the ROM.
  localparam bit BoundsEn = 1'b0;
`endif

  typedef enum logic [1:0] {StBoot, StFetch, StHalt} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              fault_q;
  logic [ADDR_W-1:0] instr_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem    [FIFO_DEPTH];
  logic [PtrW-1:0]   rd_ptr_q;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [31:0]       fetch_cnt_q;

  logic pop;
  logic push;
  logic addr_bad;
  logic slot_free;

  // Handshake, slot availability and push qualification for the current cycle.
  always_comb begin
    pop       = (count_q != '0) && out_ready;
    addr_bad  = BoundsEn && ((pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= MemLimit));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    slot_free = (count_q < Depth) || pop;
    push      = (state_q == StFetch) && !redirect_valid && !halt_req && !addr_bad && slot_free;
  end

  // Sequencer FSM: PC, state and sticky fault; redirect overrides everything but reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else if (redirect_valid) begin
      state_q <= StFetch;
      pc_q    <= {redirect_pc[ADDR_W-1:2], 2'b00};
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        StBoot: state_q <= StFetch;
        StFetch: begin
          if (addr_bad) begin
            fault_q <= 1'b1;
            state_q <= StHalt;
          end else if (halt_req) begin
            state_q <= StHalt;
          end else if (push) begin
            pc_q <= pc_q + ADDR_W'(4);
          end
        end
        StHalt: state_q <= StHalt;
        default: state_q <= StBoot;
      endcase
    end
  end

  // Output FIFO storage, pointers, occupancy and the accepted-instruction counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      fetch_cnt_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else begin
      if (pop) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (redirect_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          instr_mem[wr_ptr_q] <= imem_data;
          pc_mem[wr_ptr_q]    <= pc_q;
          wr_ptr_q            <= wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + CntW'(1);
          2'b01:   count_q <= count_q - CntW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = (count_q != '0);
  assign out_instr = instr_mem[rd_ptr_q];
  assign out_pc    = pc_mem[rd_ptr_q];
  assign busy      = (state_q == StFetch);
  assign fetch_cnt = fetch_cnt_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomized bench for ifetch_ctrl against a queue-based reference model.
module tb_ifetch_ctrl;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned NCYC   = 4000;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        busy;
  logic [31:0] fetch_cnt;
  logic        fault;

  logic [31:0] rom [256];
  assign imem_data = rom[imem_addr[9:2]];

  always #5 clk = ~clk;

  ifetch_ctrl #(
    .ADDR_W    (32),
    .RESET_PC  (RST_PC),
    .FIFO_DEPTH(DEPTH),
    .MEM_WORDS (256)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_ready     (out_ready),
    .busy          (busy),
    .fetch_cnt     (fetch_cnt),
    .fault         (fault)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: mode 0 = boot, 1 = fetching, 2 = halted.
  ent_t        m_q[$];
  logic [31:0] m_pc;
  int          m_mode;
  logic [31:0] m_cnt;
  logic        m_fault;
  logic        m_just_reset;

  task automatic model_step();
    ent_t e;
    if (!rst_n) begin
      m_q.delete();
      m_pc         = RST_PC;
      m_mode       = 0;
      m_cnt        = 0;
      m_fault      = 1'b0;
      m_just_reset = 1'b1;
    end else begin
      m_just_reset = 1'b0;
      if (m_q.size() > 0 && out_ready) begin
        void'(m_q.pop_front());
        m_cnt = m_cnt + 1;
      end
      if (redirect_valid) begin
        m_q.delete();
        m_pc    = redirect_pc & ~32'h3;
        m_mode  = 1;
        m_fault = 1'b0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
`ifdef IFETCH_BOUNDS_CHECK_EN
        if (m_pc[1:0] != 2'b00 || m_pc >= 32'd1024) begin
          m_fault = 1'b1;
          m_mode  = 2;
        end else
`endif
        if (halt_req) begin
          m_mode = 2;
        end else if (m_q.size() < DEPTH) begin
          e.pc    = m_pc;
          e.instr = rom[m_pc[9:2]];
          m_q.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_03FC;
      1:       return 32'h0000_0040;
      2:       return 32'h0000_0010;
      3:       return 32'hFFFF_FFF8;
      4:       return $urandom() & 32'h0000_03FF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int phase;
    for (int i = 0; i < 256; i++) rom[i] = $urandom();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    out_ready      = 1'b1;
    model_step();

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      check_eq("out_valid", {31'b0, out_valid}, {31'b0, (m_q.size() > 0)});
      if (m_q.size() > 0) begin
        check_eq("out_pc", out_pc, m_q[0].pc);
        check_eq("out_instr", out_instr, m_q[0].instr);
      end
      if (m_just_reset) begin
        check_eq("reset_out_pc", out_pc, 32'h0);
        check_eq("reset_out_instr", out_instr, 32'h0);
      end
      check_eq("imem_addr", imem_addr, m_pc);
      check_eq("busy", {31'b0, busy}, {31'b0, (m_mode == 1)});
      check_eq("fetch_cnt", fetch_cnt, m_cnt);
      check_eq("fault", {31'b0, fault}, {31'b0, m_fault});

      // Phases: streaming, back-pressure, halts, mixed, mixed with resets.
      phase          = (cyc / 250) % 5;
      rst_n          = (cyc >= 2);
      redirect_valid = 1'b0;
      redirect_pc    = $urandom();
      case (phase)
        0: begin
          out_ready = 1'b1;
          halt_req  = 1'b0;
          if ($urandom_range(0, 39) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = pick_target();
          end
        end
        1: begin
          out_ready = ($urandom_range(0, 9) < 3);
          halt_req  = 1'b0;
          if ($urandom_range(0, 29) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = pick_target();
          end
        end
        2: begin
          out_ready = ($urandom_range(0, 9) < 7);
          if ($urandom_range(0, 7) == 0) halt_req = ~halt_req;
          if ($urandom_range(0, 14) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = pick_target();
          end
        end
        default: begin
          out_ready = $urandom_range(0, 1);
          if ($urandom_range(0, 5) == 0) halt_req = ~halt_req;
          if ($urandom_range(0, 9) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = pick_target();
          end
          if (phase == 4 && $urandom_range(0, 49) == 0) rst_n = 1'b0;
        end
      endcase
      model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
